// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg
//   Shared definitions for the universal shift register:
//   - mode encodings driven on the 2-bit mode port
//   - cnt_width(): width of the frame bit counter for a given register width
package univ_shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // A 1-bit register still needs a 1-bit counter port, even though it only ever holds 0.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// shift_frame_cnt
//   Counts serial shifts into WIDTH-bit frames and raises a one-cycle strobe
//   on the edge that completes a frame.
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-low reset
//     clr        synchronous clear (beats en)
//     en         clock enable
//     shift      a shift (either direction) is requested this cycle
//     restart    a parallel load is requested; starts a new frame
//     bit_cnt    shifts accumulated in the current frame, 0..WIDTH-1
//     word_valid registered strobe, high for the cycle after the frame-completing edge
module shift_frame_cnt
    import univ_shift_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             shift,
    input  logic             restart,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             word_valid
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // The strobe is rewritten every cycle, so any cycle that does not complete a
    // frame (freeze, hold, load, clear) drops it back to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt    <= '0;
            word_valid <= 1'b0;
        end else if (clr) begin
            bit_cnt    <= '0;
            word_valid <= 1'b0;
        end else if (!en) begin
            word_valid <= 1'b0;
        end else if (restart) begin
            bit_cnt    <= '0;
            word_valid <= 1'b0;
        end else if (shift) begin
            if (bit_cnt == LAST) begin
                bit_cnt    <= '0;
                word_valid <= 1'b1;
            end else begin
                bit_cnt    <= bit_cnt + 1'b1;
                word_valid <= 1'b0;
            end
        end else begin
            word_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   WIDTH-bit universal shift register: hold, shift right, shift left and
//   parallel load, with a serial output and a frame counter/strobe.
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous active-low reset
//     clr          synchronous clear, highest priority after reset
//     en           clock enable for register, counter and strobe
//     mode         00 hold, 01 shift right, 10 shift left, 11 parallel load
//     serial_in    bit entering the vacated end on a shift
//     load_data    word captured on parallel load
//     parallel_out register contents
//     serial_out   q[0] in shift-right mode, q[WIDTH-1] otherwise (combinational)
//     word_valid   one-cycle strobe after each completed WIDTH-bit frame
//     bit_cnt      shifts accumulated in the current frame
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out,
    output logic             word_valid,
    output logic [CNT_W-1:0] bit_cnt
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] shl_next;
    logic [WIDTH-1:0] shr_next;
    logic             shift;
    logic             restart;

    // A single-bit register has no bits to keep on a shift: both directions
    // simply take serial_in.
    if (WIDTH == 1) begin : g_single
        assign shl_next = serial_in;
        assign shr_next = serial_in;
    end else begin : g_multi
        assign shl_next = {q[WIDTH-2:0], serial_in};
        assign shr_next = {serial_in, q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            case (mode)
                MODE_HOLD: q <= q;
                MODE_SHR:  q <= shr_next;
                MODE_SHL:  q <= shl_next;
                MODE_LOAD: q <= load_data;
            endcase
        end
    end

    assign shift   = (mode == MODE_SHR) || (mode == MODE_SHL);
    assign restart = (mode == MODE_LOAD);

    shift_frame_cnt #(.WIDTH(WIDTH)) u_frame_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .en         (en),
        .shift      (shift),
        .restart    (restart),
        .bit_cnt    (bit_cnt),
        .word_valid (word_valid)
    );

    assign parallel_out = q;
    // The bit about to leave: LSB when shifting right, MSB otherwise (PISO use).
    assign serial_out   = (mode == MODE_SHR) ? q[0] : q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       clr  = 1'b0;
    logic       en   = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       sin  = 1'b0;
    logic [3:0] ld   = 4'h0;

    logic [3:0] po4;
    logic       so4, wv4;
    logic [1:0] bc4;
    logic [0:0] po1;
    logic       so1, wv1;
    logic [0:0] bc1;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: register value as an integer, shift count, strobe.
    int q4 = 0, c4 = 0, q1 = 0, c1 = 0;
    bit v4 = 0, v1 = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode),
        .serial_in(sin), .load_data(ld),
        .parallel_out(po4), .serial_out(so4), .word_valid(wv4), .bit_cnt(bc4)
    );

    univ_shift_reg #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode),
        .serial_in(sin), .load_data(ld[0:0]),
        .parallel_out(po1), .serial_out(so1), .word_valid(wv1), .bit_cnt(bc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Behavioural model of one rising edge for a w-bit register.
    task automatic model_edge(input int w, inout int q, inout int cnt, inout bit wv);
        int pw;
        pw = 1 << w;
        if (clr) begin
            q = 0; cnt = 0; wv = 0;
        end else if (!en) begin
            wv = 0;
        end else if (mode == 2'b11) begin
            q = int'(ld) % pw; cnt = 0; wv = 0;
        end else if (mode == 2'b00) begin
            wv = 0;
        end else begin
            if (mode == 2'b10) q = (q * 2 + int'(sin)) % pw;
            else               q = q / 2 + int'(sin) * (pw / 2);
            cnt = cnt + 1;
            wv  = (cnt == w);
            if (wv) cnt = 0;
        end
    endtask

    function automatic int exp_so(input int w, input int q, input logic [1:0] m);
        return (m == 2'b01) ? (q % 2) : ((q >> (w - 1)) & 1);
    endfunction

    task automatic check_state(input string t);
        chk({t, "/po4"}, 32'(po4), q4);
        chk({t, "/bc4"}, 32'(bc4), c4);
        chk({t, "/wv4"}, 32'(wv4), 32'(v4));
        chk({t, "/po1"}, 32'(po1), q1);
        chk({t, "/bc1"}, 32'(bc1), c1);
        chk({t, "/wv1"}, 32'(wv1), 32'(v1));
    endtask

    // Drive one cycle's inputs, check serial_out before the edge, then the state after it.
    task automatic cycle(input logic c, input logic e, input logic [1:0] m,
                         input logic s, input logic [3:0] d, input string t);
        clr = c; en = e; mode = m; sin = s; ld = d;
        #1;
        chk({t, "/so4"}, 32'(so4), exp_so(4, q4, m));
        chk({t, "/so1"}, 32'(so1), exp_so(1, q1, m));
        @(posedge clk);
        model_edge(4, q4, c4, v4);
        model_edge(1, q1, c1, v1);
        #1;
        check_state(t);
    endtask

    logic [3:0] bits_a   = 4'b1101;  // serial_in 1,0,1,1 by index 0..3
    logic [3:0] shl_exp [4] = '{4'h1, 4'h2, 4'h5, 4'hB};
    logic [3:0] so_exp   = 4'b1001;  // serial_out 1,0,0,1 by index 3..0

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        check_state("reset");
        chk("reset/po4_zero", 32'(po4), 0);
        rst = 1'b1;

        // Shift left 1,0,1,1 from reset
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 2'b10, bits_a[i], 4'h0, "shl");
            chk("shl/po4_const", 32'(po4), 32'(shl_exp[i]));
            chk("shl/wv4_const", 32'(wv4), (i == 3) ? 1 : 0);
            chk("shl/wv1_const", 32'(wv1), 1);
        end

        // Shift right 1,0,1,1 from cleared, then a fifth shift of 0
        cycle(1, 0, 2'b00, 0, 4'h0, "clr");
        for (int i = 0; i < 4; i++) cycle(0, 1, 2'b01, bits_a[i], 4'h0, "shr");
        chk("shr/po4_const", 32'(po4), 32'hD);
        cycle(0, 1, 2'b01, 0, 4'h0, "shr5");
        chk("shr5/po4_const", 32'(po4), 32'h6);
        chk("shr5/bc4_const", 32'(bc4), 1);

        // Load 1001 then serialise MSB-first
        cycle(0, 1, 2'b11, 0, 4'h9, "load");
        for (int i = 3; i >= 0; i--) begin
            clr = 0; en = 1; mode = 2'b10; sin = 0;
            #1;
            chk("piso/so4_const", 32'(so4), 32'(so_exp[i]));
            cycle(0, 1, 2'b10, 0, 4'h0, "piso");
        end
        chk("piso/po4_end", 32'(po4), 0);
        chk("piso/wv4_end", 32'(wv4), 1);

        // Freeze mid-frame
        cycle(1, 1, 2'b00, 0, 4'h0, "clr2");
        cycle(0, 1, 2'b10, 1, 4'h0, "frz_a");
        cycle(0, 1, 2'b01, 1, 4'h0, "frz_a");
        chk("frz/bc4_two", 32'(bc4), 2);
        for (int i = 0; i < 3; i++) cycle(0, 0, 2'b10, 1, 4'h0, "frz_off");
        cycle(0, 1, 2'b10, 0, 4'h0, "frz_b");
        chk("frz/wv4_3rd", 32'(wv4), 0);
        cycle(0, 1, 2'b10, 1, 4'h0, "frz_b");
        chk("frz/wv4_4th", 32'(wv4), 1);

        // Asynchronous reset between edges after two shifts
        cycle(0, 1, 2'b10, 1, 4'h0, "rst_pre");
        cycle(0, 1, 2'b10, 1, 4'h0, "rst_pre");
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst/po4", 32'(po4), 0);
        chk("async_rst/bc4", 32'(bc4), 0);
        chk("async_rst/wv4", 32'(wv4), 0);
        chk("async_rst/po1", 32'(po1), 0);
        q4 = 0; c4 = 0; v4 = 0; q1 = 0; c1 = 0; v1 = 0;
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) cycle(0, 1, 2'b10, 1, 4'h0, "post_rst");
        chk("post_rst/wv4", 32'(wv4), 1);

        // Clear beats load
        cycle(1, 1, 2'b11, 0, 4'hF, "clr_load");
        chk("clr_load/po4", 32'(po4), 0);
        chk("clr_load/bc4", 32'(bc4), 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
